spi_xfer_sequencer: RTL

SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

---
 rtl/spi_xfer_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// spi_xfer_sequencer
//
// Sequences one multi-byte SPI transaction over a byte-level SPI master.
// It drives chip select, paces CS setup/hold/inactive time, moves bytes from
// the user TX stream to the master one at a time, and returns each received
// byte to the user in issue order.
//
// Ports
//   i_Clk, i_Rst                 clock; asynchronous active-high reset
//   i_Start, i_Len               transaction request pulse and byte count
//   i_TX_Valid, i_TX_Byte,
//   o_TX_Ready                   user TX byte stream (valid/ready)
//   o_RX_DV, o_RX_Byte,
//   o_RX_Last                    received byte pulse; Last marks final byte
//   o_Busy, o_Done               activity flag; one-cycle completion pulse
//   o_M_TX_Byte, o_M_TX_DV,
//   i_M_TX_Ready, i_M_RX_DV,
//   i_M_RX_Byte                  byte-level SPI master link
//   o_SPI_CS_n                   active-low chip select (registered)
// ---------------------------------------------------------------------------
module spi_xfer_sequencer #(
    parameter int CS_SETUP_CLKS    = 2,
    parameter int CS_HOLD_CLKS     = 2,
    parameter int CS_INACTIVE_CLKS = 4,
    parameter int MAX_BYTES        = 16,
    localparam int LEN_W           = $clog2(MAX_BYTES + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [LEN_W-1:0] i_Len,
    input  logic             i_TX_Valid,
    input  logic [7:0]       i_TX_Byte,
    output logic             o_TX_Ready,
    output logic             o_RX_DV,
    output logic [7:0]       o_RX_Byte,
    output logic             o_RX_Last,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [7:0]       o_M_TX_Byte,
    output logic             o_M_TX_DV,
    input  logic             i_M_TX_Ready,
    input  logic             i_M_RX_DV,
    input  logic [7:0]       i_M_RX_Byte,
    output logic             o_SPI_CS_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TX_WAIT,
        ISSUE,
        RX_WAIT,
        HOLD,
        INACTIVE
    } state_t;

    // Phase counters count down to zero, so each phase loads (length - 1).
    localparam logic [7:0] SETUP_LOAD    = 8'(CS_SETUP_CLKS - 1);
    localparam logic [7:0] HOLD_LOAD     = 8'(CS_HOLD_CLKS - 1);
    localparam logic [7:0] INACTIVE_LOAD = 8'(CS_INACTIVE_CLKS - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             cs_n_q, cs_n_d;
    logic [7:0]       m_tx_byte_q, m_tx_byte_d;
    logic             rx_dv_q, rx_dv_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_last_q, rx_last_d;
    logic             done_q, done_d;

    logic             len_ok;
    logic             tx_ready;

    assign len_ok   = (i_Len != '0) && (i_Len <= LEN_W'(MAX_BYTES));
    // Ready is a pure decode of the state register and the master's ready,
    // so it falls to zero the moment reset forces IDLE.
    assign tx_ready = (state_q == TX_WAIT) && i_M_TX_Ready;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        cs_n_d      = cs_n_q;
        m_tx_byte_d = m_tx_byte_q;
        rx_dv_d     = 1'b0;
        rx_byte_d   = rx_byte_q;
        rx_last_d   = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Bad lengths and starts in any other state are dropped.
                if (i_Start && len_ok) begin
                    rem_d   = i_Len;
                    cs_n_d  = 1'b0;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) state_d = TX_WAIT;
                else               cnt_d   = cnt_q - 8'd1;
            end
            TX_WAIT: begin
                // No timeout: a stalled TX stream simply holds CS low.
                if (i_TX_Valid && tx_ready) begin
                    m_tx_byte_d = i_TX_Byte;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RX_WAIT;
            end
            RX_WAIT: begin
                if (i_M_RX_DV) begin
                    rx_byte_d = i_M_RX_Byte;
                    rx_dv_d   = 1'b1;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        rx_last_d = 1'b1;
                        cnt_d     = HOLD_LOAD;
                        state_d   = HOLD;
                    end else begin
                        state_d = TX_WAIT;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = INACTIVE_LOAD;
                    state_d = INACTIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            INACTIVE: begin
                if (cnt_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            rem_q       <= '0;
            cs_n_q      <= 1'b1;
            m_tx_byte_q <= 8'd0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= 8'd0;
            rx_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            cs_n_q      <= cs_n_d;
            m_tx_byte_q <= m_tx_byte_d;
            rx_dv_q     <= rx_dv_d;
            rx_byte_q   <= rx_byte_d;
            rx_last_q   <= rx_last_d;
            done_q      <= done_d;
        end
    end

    assign o_TX_Ready  = tx_ready;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = (state_q == ISSUE);
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_RX_Last   = rx_last_q;
    assign o_Busy      = (state_q != IDLE);
    assign o_Done      = done_q;
    assign o_SPI_CS_n  = cs_n_q;

endmodule
